// File: rtl/axi_register_slice_if.sv
// ============================================================================
//  Module      : axi_if
//  Description : AXI4 signal bundle used on both sides of axi_register_slice.
//                The "slave" modport is the view of a block that receives
//                requests (AW/W/AR in, B/R out). The "master" modport is the
//                view of a block that issues them.
//  Parameters  : ADDR_WIDTH  - awaddr/araddr width
//                DATA_WIDTH  - wdata/rdata width (multiple of 8)
//                USER_WIDTH  - wuser/buser/ruser width
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Write address channel
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;
  // Write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic [USER_WIDTH-1:0] wuser;
  logic                  wvalid;
  logic                  wready;
  // Write response channel
  logic [1:0]            bresp;
  logic [USER_WIDTH-1:0] buser;
  logic                  bvalid;
  logic                  bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  // Read data channel
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic [USER_WIDTH-1:0] ruser;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bresp, buser, bvalid,
    input  bready,
    input  araddr, arlen, arvalid,
    output arready,
    output rdata, rlast, ruser, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bresp, buser, bvalid,
    output bready,
    output araddr, arlen, arvalid,
    input  arready,
    input  rdata, rlast, ruser, rresp, rvalid,
    output rready
  );

endinterface

`default_nettype wire

// File: rtl/axi_register_slice.sv
// ============================================================================
//  Module      : axi_register_slice
//  Description : Full AXI4 register slice. Every channel (AW, W, B, AR, R)
//                passes through its own two-entry skid buffer, so no valid,
//                ready or payload path crosses combinationally between the
//                upstream master and the downstream slave, while each channel
//                still sustains one beat per cycle.
//  Ports       : clk    - single rising-edge clock
//                rst    - synchronous active-high reset
//                s_axi  - slave side, driven by the upstream master
//                m_axi  - master side, drives the downstream slave
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
//  axi_register_slice_skid
//  Two-entry skid buffer: a main register that feeds the sink and a skid
//  register that catches the beat accepted in the cycle the sink stalls.
//  Ports: in_valid_i/in_ready_o/in_data_i   - source side handshake + payload
//         out_valid_o/out_ready_i/out_data_o - sink side handshake + payload
// ----------------------------------------------------------------------------
module axi_register_slice_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             ready_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid_i & ready_q;
  assign out_fire = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (out_fire) begin
      main_valid_d = 1'b0;
    end

    // Ready is ~skid_valid, so no new beat can arrive while skid is occupied;
    // the only thing to do then is promote skid into main once main drains.
    if (skid_valid_q) begin
      if (out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        // Reloading main in the same cycle it drains keeps full throughput.
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      // Registered from the next skid state, so ready depends only on flops.
      ready_q      <= ~skid_valid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

endmodule

// ----------------------------------------------------------------------------
//  axi_register_slice (top)
// ----------------------------------------------------------------------------
module axi_register_slice #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input  logic  clk,
  input  logic  rst,
  axi_if.slave  s_axi,
  axi_if.master m_axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int AW_PW      = ADDR_WIDTH + 8;
  localparam int W_PW       = DATA_WIDTH + STRB_WIDTH + 1 + USER_WIDTH;
  localparam int B_PW       = 2 + USER_WIDTH;
  localparam int AR_PW      = ADDR_WIDTH + 8;
  localparam int R_PW       = DATA_WIDTH + 1 + USER_WIDTH + 2;

  logic [AW_PW-1:0] aw_out;
  logic [W_PW-1:0]  w_out;
  logic [B_PW-1:0]  b_out;
  logic [AR_PW-1:0] ar_out;
  logic [R_PW-1:0]  r_out;

  // AW: upstream -> downstream
  axi_register_slice_skid #(.WIDTH(AW_PW)) u_aw (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s_axi.awvalid),
    .in_ready_o  (s_axi.awready),
    .in_data_i   ({s_axi.awlen, s_axi.awaddr}),
    .out_valid_o (m_axi.awvalid),
    .out_ready_i (m_axi.awready),
    .out_data_o  (aw_out)
  );
  assign {m_axi.awlen, m_axi.awaddr} = aw_out;

  // W: upstream -> downstream
  axi_register_slice_skid #(.WIDTH(W_PW)) u_w (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s_axi.wvalid),
    .in_ready_o  (s_axi.wready),
    .in_data_i   ({s_axi.wuser, s_axi.wlast, s_axi.wstrb, s_axi.wdata}),
    .out_valid_o (m_axi.wvalid),
    .out_ready_i (m_axi.wready),
    .out_data_o  (w_out)
  );
  assign {m_axi.wuser, m_axi.wlast, m_axi.wstrb, m_axi.wdata} = w_out;

  // B: downstream -> upstream
  axi_register_slice_skid #(.WIDTH(B_PW)) u_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (m_axi.bvalid),
    .in_ready_o  (m_axi.bready),
    .in_data_i   ({m_axi.buser, m_axi.bresp}),
    .out_valid_o (s_axi.bvalid),
    .out_ready_i (s_axi.bready),
    .out_data_o  (b_out)
  );
  assign {s_axi.buser, s_axi.bresp} = b_out;

  // AR: upstream -> downstream
  axi_register_slice_skid #(.WIDTH(AR_PW)) u_ar (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s_axi.arvalid),
    .in_ready_o  (s_axi.arready),
    .in_data_i   ({s_axi.arlen, s_axi.araddr}),
    .out_valid_o (m_axi.arvalid),
    .out_ready_i (m_axi.arready),
    .out_data_o  (ar_out)
  );
  assign {m_axi.arlen, m_axi.araddr} = ar_out;

  // R: downstream -> upstream
  axi_register_slice_skid #(.WIDTH(R_PW)) u_r (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (m_axi.rvalid),
    .in_ready_o  (m_axi.rready),
    .in_data_i   ({m_axi.ruser, m_axi.rresp, m_axi.rlast, m_axi.rdata}),
    .out_valid_o (s_axi.rvalid),
    .out_ready_i (s_axi.rready),
    .out_data_o  (r_out)
  );
  assign {s_axi.ruser, s_axi.rresp, s_axi.rlast, s_axi.rdata} = r_out;

endmodule

`default_nettype wire

// File: tb/tb_axi_register_slice.sv
// ============================================================================
//  Module      : tb_axi_register_slice
//  Description : Self-checking bench for axi_register_slice. Channels are
//                handled generically by index: 0=AW 1=W 2=AR 3=B 4=R, each
//                with a packed payload word. A per-channel FIFO model (depth 2,
//                valid = non-empty, ready = not full) runs on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_register_slice;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int UW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
  axi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

  axi_register_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (s_if),
    .m_axi (m_if)
  );

  // Bench-side source/sink controls and observed sink/source signals
  logic [4:0]  src_v;
  logic [4:0]  snk_r;
  logic [63:0] src_d [5];
  wire  [4:0]  out_v;
  wire  [4:0]  in_rdy;
  logic [63:0] out_d [5];

  // AW
  assign s_if.awaddr  = src_d[0][9:0];
  assign s_if.awlen   = src_d[0][17:10];
  assign s_if.awvalid = src_v[0];
  assign m_if.awready = snk_r[0];
  assign out_d[0]     = {46'b0, m_if.awlen, m_if.awaddr};
  // W
  assign s_if.wdata   = src_d[1][31:0];
  assign s_if.wstrb   = src_d[1][35:32];
  assign s_if.wlast   = src_d[1][36];
  assign s_if.wuser   = src_d[1][37];
  assign s_if.wvalid  = src_v[1];
  assign m_if.wready  = snk_r[1];
  assign out_d[1]     = {26'b0, m_if.wuser, m_if.wlast, m_if.wstrb, m_if.wdata};
  // AR
  assign s_if.araddr  = src_d[2][9:0];
  assign s_if.arlen   = src_d[2][17:10];
  assign s_if.arvalid = src_v[2];
  assign m_if.arready = snk_r[2];
  assign out_d[2]     = {46'b0, m_if.arlen, m_if.araddr};
  // B
  assign m_if.bresp   = src_d[3][1:0];
  assign m_if.buser   = src_d[3][2];
  assign m_if.bvalid  = src_v[3];
  assign s_if.bready  = snk_r[3];
  assign out_d[3]     = {61'b0, s_if.buser, s_if.bresp};
  // R
  assign m_if.rdata   = src_d[4][31:0];
  assign m_if.rlast   = src_d[4][32];
  assign m_if.rresp   = src_d[4][34:33];
  assign m_if.ruser   = src_d[4][35];
  assign m_if.rvalid  = src_v[4];
  assign s_if.rready  = snk_r[4];
  assign out_d[4]     = {28'b0, s_if.ruser, s_if.rresp, s_if.rlast, s_if.rdata};

  assign out_v  = {s_if.rvalid, s_if.bvalid, m_if.arvalid, m_if.wvalid, m_if.awvalid};
  assign in_rdy = {m_if.rready, m_if.bready, s_if.arready, s_if.wready, s_if.awready};

  string       chn  [5] = '{"AW", "W", "AR", "B", "R"};
  logic [63:0] mask [5];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-channel FIFO of accepted beats
  logic [63:0] sb [5][4096];
  int          wr [5];
  int          rd [5];
  int          nout [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock, update the FIFO model with the handshakes that happened
  // at this edge, then compare every channel against the model.
  task automatic step();
    logic [4:0] inf;
    logic [4:0] outf;
    logic       rs;
    inf  = src_v & in_rdy;
    outf = out_v & snk_r;
    rs   = rst;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      if (rs === 1'b1) begin
        rd[c] = wr[c];
      end else begin
        if (outf[c] === 1'b1 && rd[c] < wr[c]) begin
          rd[c]++;
          nout[c]++;
        end
        if (inf[c] === 1'b1) begin
          sb[c][wr[c] % 4096] = src_d[c];
          wr[c]++;
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      int occ;
      occ = wr[c] - rd[c];
      chk($sformatf("model %s vld/rdy t=%0t", chn[c], $time), {62'b0, out_v[c], in_rdy[c]},
          {62'b0, occ > 0, (rs !== 1'b1) && (occ < 2)});
      if (occ > 0)
        chk($sformatf("model %s payload t=%0t", chn[c], $time), out_d[c], sb[c][rd[c] % 4096]);
    end
  endtask

  function automatic logic [63:0] wbeat(input int i);
    return {26'b0, 1'b0, 1'(i == 7), 4'hF, 32'hB000_0000 + 32'(i)};
  endfunction

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        rdy;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int acc;
    int got;
    int cyc;
    int pv;
    int pr;
    logic [4:0]  fire;
    logic        fo;
    logic        fi;
    logic [63:0] od;
    logic        all_done;

    // W-channel vectors: inputs for the cycle, expected sink/source view after
    // the edge. Covers accept+drain reload, skid fill, skid->main promotion.
    tbl[0]  = '{1'b1, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_0001, 1'b1};
    tbl[1]  = '{1'b1, 32'h0000_0002, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
    tbl[2]  = '{1'b1, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0002, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0003, 1'b1};
    tbl[5]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0004, 1'b1};
    tbl[6]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    tbl[7]  = '{1'b1, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0005, 1'b1};
    tbl[8]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b1, 32'h0000_0005, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0006, 1'b1};
    tbl[10] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};

    mask[0] = 64'h3_FFFF;
    mask[1] = 64'h3F_FFFF_FFFF;
    mask[2] = 64'h3_FFFF;
    mask[3] = 64'h7;
    mask[4] = 64'hF_FFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      src_d[c] = '0;
      wr[c] = 0;
      rd[c] = 0;
      nout[c] = 0;
    end
    src_v = '0;
    snk_r = '0;
    rst   = 1'b1;

    // ---------------- Reset state ----------------
    repeat (3) step();
    chk("reset valids", {59'b0, out_v}, 64'h0);
    chk("reset readies", {59'b0, in_rdy}, 64'h0);
    for (int c = 0; c < 5; c++)
      chk($sformatf("reset payload %s", chn[c]), out_d[c], 64'h0);
    rst = 1'b0;
    snk_r = 5'h1F;
    step();
    chk("post-reset readies", {59'b0, in_rdy}, 64'h1F);
    chk("post-reset valids", {59'b0, out_v}, 64'h0);

    // ---------------- Write burst ----------------
    src_v[0] = 1'b1;
    src_d[0] = {46'b0, 8'd3, 10'h010};
    for (int k = 0; k < 4; k++) begin
      src_v[1] = 1'b1;
      src_d[1] = {26'b0, 1'b0, 1'(k == 3), 4'hF, 32'(32'h1111_1111 * (k + 1))};
      step();
      if (k == 0) begin
        chk("wr burst AW out", {45'b0, out_v[0], out_d[0][17:0]}, {45'b0, 1'b1, 8'd3, 10'h010});
        src_v[0] = 1'b0;
      end
      chk($sformatf("wr burst W beat %0d", k), {25'b0, out_v[1], out_d[1][37:0]},
          {25'b0, 1'b1, 1'b0, 1'(k == 3), 4'hF, 32'(32'h1111_1111 * (k + 1))});
    end
    src_v[1] = 1'b0;
    step();
    chk("wr burst W idle", {63'b0, out_v[1]}, 64'h0);
    src_v[3] = 1'b1;
    src_d[3] = 64'h0;
    step();
    src_v[3] = 1'b0;
    chk("wr burst B out", {60'b0, out_v[3], out_d[3][2:0]}, {60'b0, 1'b1, 3'b000});

    // ---------------- Read burst ----------------
    src_v[2] = 1'b1;
    src_d[2] = {46'b0, 8'd7, 10'h020};
    step();
    src_v[2] = 1'b0;
    chk("rd burst AR out", {45'b0, out_v[2], out_d[2][17:0]}, {45'b0, 1'b1, 8'd7, 10'h020});
    for (int i = 0; i < 8; i++) begin
      src_v[4] = 1'b1;
      src_d[4] = {28'b0, 1'b0, 2'b00, 1'(i == 7), 32'(i)};
      step();
      chk($sformatf("rd burst R beat %0d", i), {27'b0, out_v[4], out_d[4][35:0]},
          {27'b0, 1'b1, 1'b0, 2'b00, 1'(i == 7), 32'(i)});
    end
    src_v[4] = 1'b0;
    step();
    chk("rd burst R idle", {63'b0, out_v[4]}, 64'h0);

    // ---------------- Table-driven W sequence ----------------
    for (int i = 0; i < 11; i++) begin
      src_v[1] = tbl[i].vin;
      src_d[1] = {26'b0, 1'b0, 1'b0, 4'hF, tbl[i].din};
      snk_r[1] = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d vld/rdy", i), {62'b0, out_v[1], in_rdy[1]},
          {62'b0, tbl[i].exp_v, tbl[i].exp_rdy});
      if (tbl[i].exp_v)
        chk($sformatf("tbl%0d data", i), {32'b0, out_d[1][31:0]}, {32'b0, tbl[i].exp_d});
    end
    src_v[1] = 1'b0;
    snk_r[1] = 1'b1;

    // ---------------- Backpressure ----------------
    acc = 0;
    src_v[1] = 1'b1;
    src_d[1] = wbeat(0);
    snk_r[1] = 1'b0;
    repeat (5) begin
      fi = src_v[1] & in_rdy[1];
      step();
      if (fi) begin
        acc++;
        src_d[1] = wbeat(acc);
      end
    end
    chk("bp absorbed beats", 64'(acc), 64'd2);
    chk("bp wready low", {63'b0, in_rdy[1]}, 64'h0);
    snk_r[1] = 1'b1;
    got = 0;
    for (int t = 0; t < 30 && got < 8; t++) begin
      fi = src_v[1] & in_rdy[1];
      fo = out_v[1] & snk_r[1];
      od = out_d[1];
      step();
      if (fo) begin
        chk($sformatf("bp drain beat %0d", got), od, wbeat(got));
        got++;
      end
      if (fi) begin
        acc++;
        if (acc < 8) src_d[1] = wbeat(acc);
        else src_v[1] = 1'b0;
      end
    end
    chk("bp drained count", 64'(got), 64'd8);
    src_v[1] = 1'b0;
    step();

    // ---------------- Reset mid-burst ----------------
    src_v[1] = 1'b1;
    src_d[1] = wbeat(100);
    snk_r[1] = 1'b0;
    repeat (3) step();
    chk("rst-mid W full", {62'b0, out_v[1], in_rdy[1]}, {62'b0, 1'b1, 1'b0});
    rst = 1'b1;
    step();
    chk("rst-mid valids", {59'b0, out_v}, 64'h0);
    chk("rst-mid readies", {59'b0, in_rdy}, 64'h0);
    chk("rst-mid W payload", out_d[1], 64'h0);
    rst = 1'b0;
    src_v = '0;
    snk_r = 5'h1F;
    step();
    chk("rst-mid release readies", {59'b0, in_rdy}, 64'h1F);
    chk("rst-mid release valids", {59'b0, out_v}, 64'h0);
    repeat (3) begin
      step();
      chk("rst-mid no stale W", {63'b0, out_v[1]}, 64'h0);
    end

    // ---------------- Randomized traffic ----------------
    for (int c = 0; c < 5; c++) nout[c] = 0;
    pv = 70;
    pr = 70;
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 20000) begin
      if (cyc % 150 == 0) begin
        case ($urandom_range(0, 3))
          0: begin pv = 100; pr = 100; end
          1: begin pv = 90;  pr = 30;  end
          2: begin pv = 30;  pr = 90;  end
          default: begin pv = 60; pr = 60; end
        endcase
      end
      fire = src_v & in_rdy;
      step();
      for (int c = 0; c < 5; c++) begin
        // A source must hold valid and payload until its beat is accepted.
        if (!src_v[c] || fire[c]) begin
          src_v[c] = ($urandom_range(0, 99) < pv);
          src_d[c] = {$urandom, $urandom} & mask[c];
        end
        snk_r[c] = ($urandom_range(0, 99) < pr);
      end
      cyc++;
      all_done = (nout[0] >= 300) && (nout[1] >= 300) && (nout[2] >= 300) &&
                 (nout[3] >= 300) && (nout[4] >= 300);
    end
    chk("random traffic completed", {63'b0, all_done}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
